memory_responder: RTL and testbench

Memory-side endpoint of the CPU's MFA/MFC memory handshake. It accepts a read or write request from the control unit (address from MAR, data from MBR, READ_WRITE, WORD_BYTE), performs a byte- or word-wide access to an internal byte-addressed RAM after a programmable wait, and signals completion with MFC. It sits between the MAR/MBR datapath and the rest of the CPU and stands in for main memory in simulation and on FPGA.

---
 rtl/memory_responder.sv | 120 ++++++++++++
 tb/tb_memory_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Memory-side MFA/MFC endpoint with a byte-addressed RAM and a programmable access delay.
// Optional MEM_ALIGN_CHECK_EN adds an ERR output that rejects misaligned word accesses.
module memory_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MFA,
  input  logic        READ_WRITE,
  input  logic        WORD_BYTE,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        MFC,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        ERR,
`endif
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken when MFA is sampled high in IDLE; MFC stays high in DONE
  // until MFA is sampled low, so every request needs MFA low for at least one edge in between.
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t                  state, state_nx;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [31:0]             req_data;
  logic                    req_read;
  logic                    req_word;
  logic                    misaligned;
  logic [7:0]              mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0]   a0, a1, a2, a3;
  logic [31:0]             rd_word;
  logic [31:0]             rd_byte;
  logic                    unused_addr_hi;

  assign unused_addr_hi = ^Address[31:ADDR_WIDTH];

  // Word accesses align down; the low byte lanes always sit inside one aligned word.
  assign a0 = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign a1 = {req_addr[ADDR_WIDTH-1:2], 2'b01};
  assign a2 = {req_addr[ADDR_WIDTH-1:2], 2'b10};
  assign a3 = {req_addr[ADDR_WIDTH-1:2], 2'b11};
  assign rd_word = {mem[a3], mem[a2], mem[a1], mem[a0]};
  assign rd_byte = {24'b0, mem[req_addr]};

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;
  assign misaligned = req_word && (req_addr[1:0] != 2'b00);
  assign ERR        = MFC && err_q;
`else
  assign misaligned = 1'b0;
`endif

  assign MFC       = (state == S_DONE);
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (MFA) state_nx = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (cnt <= 4'd1) state_nx = S_ACCESS;
      S_ACCESS: state_nx = S_DONE;
      S_DONE:   if (!MFA) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      req_addr <= '0;
      req_data <= 32'd0;
      req_read <= 1'b0;
      req_word <= 1'b0;
      DataOut  <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (MFA) begin
          cnt      <= 4'(WAIT_CYCLES);
          req_addr <= Address[ADDR_WIDTH-1:0];
          req_data <= DataIn;
          req_read <= READ_WRITE;
          req_word <= WORD_BYTE;
        end
        S_WAIT: cnt <= cnt - 4'd1;
        S_ACCESS: begin
          if (misaligned)    DataOut <= 32'd0;
          else if (req_read) DataOut <= req_word ? rd_word : rd_byte;
`ifdef MEM_ALIGN_CHECK_EN
          err_q <= misaligned;
`endif
        end
        default: ;
      endcase
    end
  end

  // RAM survives Reset; a reset before ACCESS leaves state out of S_ACCESS, dropping the write.
  always_ff @(posedge Clk) begin
    if (state == S_ACCESS && !req_read && !misaligned) begin
      if (req_word) begin
        mem[a0] <= req_data[7:0];
        mem[a1] <= req_data[15:8];
        mem[a2] <= req_data[23:16];
        mem[a3] <= req_data[31:24];
      end else begin
        mem[req_addr] <= req_data[7:0];
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: edge-timestamp reference model, per-cycle compare, directed and random requests.
module tb_memory_responder;
  localparam int AW = 8;
  localparam int WC = 2;
  localparam int MSIZE = 1 << AW;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        MFA = 1'b0;
  logic        READ_WRITE = 1'b0;
  logic        WORD_BYTE = 1'b0;
  logic [31:0] Address = 32'd0;
  logic [31:0] DataIn = 32'd0;
  logic [31:0] DataOut;
  logic        MFC;
  logic [1:0]  dbg_state;
`ifdef MEM_ALIGN_CHECK_EN
  logic        ERR;
`endif

  memory_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .Clk(Clk), .Reset(Reset), .MFA(MFA), .READ_WRITE(READ_WRITE), .WORD_BYTE(WORD_BYTE),
    .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC),
`ifdef MEM_ALIGN_CHECK_EN
    .ERR(ERR),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: request captured at edge c completes its access at edge c+WC+1
  logic [7:0]  mmem [MSIZE];
  int          edge_cnt = 0;
  int          acc_edge = 0;
  bit          m_active = 0, m_done = 0, m_chk = 0, m_err = 0;
  logic [31:0] m_data = 32'd0;
  logic [31:0] p_addr, p_data;
  bit          p_read, p_word;

  task automatic model_access();
    int a, base;
    bit mis;
    a = int'(p_addr % MSIZE);
    base = a - (a % 4);
`ifdef MEM_ALIGN_CHECK_EN
    mis = p_word && (a % 4 != 0);
`else
    mis = 0;
`endif
    m_err = mis;
    if (mis) begin
      m_data = 32'd0; m_chk = 1;
    end else if (p_read) begin
      if (p_word) m_data = {mmem[base+3], mmem[base+2], mmem[base+1], mmem[base]};
      else        m_data = {24'd0, mmem[a]};
      m_chk = 1;
    end else begin
      if (p_word) for (int k = 0; k < 4; k++) mmem[base+k] = p_data[8*k +: 8];
      else        mmem[a] = p_data[7:0];
      m_chk = 0;
    end
  endtask

  always @(posedge Clk) begin
    edge_cnt++;
    if (Reset) begin
      m_active = 0; m_done = 0; m_err = 0;
    end else if (!m_active) begin
      if (MFA) begin
        p_addr = Address; p_data = DataIn; p_read = READ_WRITE; p_word = WORD_BYTE;
        acc_edge = edge_cnt + WC + 1;
        m_active = 1;
      end
    end else if (!m_done) begin
      if (edge_cnt == acc_edge) begin
        model_access();
        m_done = 1;
      end
    end else if (!MFA) begin
      m_active = 0; m_done = 0;
    end
  end

  // scoreboard compare, every cycle, away from the active edge
  always @(posedge Clk) begin
    #2;
    check("mfc", {31'd0, MFC}, {31'd0, m_done});
    if (m_done && m_chk) check("dataout", DataOut, m_data);
`ifdef MEM_ALIGN_CHECK_EN
    check("err", {31'd0, ERR}, {31'd0, (m_done && m_err)});
`endif
  end

  // driver: one full MFA/MFC transaction
  task automatic txn(input bit rd, input bit wd, input logic [31:0] addr, input logic [31:0] data,
                     input int hold, input bit early,
                     output logic [31:0] data_o, output int lat, output logic err_o);
    int e0, n;
    @(negedge Clk);
    MFA = 1; READ_WRITE = rd; WORD_BYTE = wd; Address = addr; DataIn = data;
    e0 = edge_cnt + 1;
    if (early) begin
      @(negedge Clk);
      MFA = 0; Address = $urandom; DataIn = $urandom; READ_WRITE = $urandom_range(0, 1);
    end
    n = 0;
    while (!MFC && n < 50) begin @(negedge Clk); n++; end
    check("mfc_rise_timeout", {31'd0, MFC}, 32'd1);
    lat = edge_cnt - e0 + 1;
    data_o = DataOut;
`ifdef MEM_ALIGN_CHECK_EN
    err_o = ERR;
`else
    err_o = 1'b0;
`endif
    Address = $urandom; DataIn = $urandom; WORD_BYTE = $urandom_range(0, 1);
    repeat (hold) @(negedge Clk);
    MFA = 0;
    n = 0;
    while (MFC && n < 50) begin @(negedge Clk); n++; end
    check("mfc_fall_timeout", {31'd0, MFC}, 32'd0);
  endtask

  logic [31:0] d;
  logic        e;
  int          lat;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge Clk);
    check("reset_mfc", {31'd0, MFC}, 32'd0);
    check("reset_dataout", DataOut, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    Reset = 0;

    for (int i = 0; i < MSIZE / 4; i++) txn(0, 1, 32'(i * 4), $urandom, 0, 0, d, lat, e);

    txn(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, d, lat, e);
    txn(1, 1, 32'h10, 32'h0, 0, 0, d, lat, e);
    check("word_read_10", d, 32'hDEADBEEF);
    check("latency_edges", 32'(lat), 32'd4);
    txn(1, 0, 32'h11, 32'h0, 0, 0, d, lat, e);
    check("byte_read_11", d, 32'h000000BE);
    txn(0, 0, 32'h12, 32'h55, 0, 0, d, lat, e);
    txn(1, 1, 32'h10, 32'h0, 10, 0, d, lat, e);
    check("word_read_after_byte_write", d, 32'hDE55BEEF);

    txn(0, 1, 32'h20, 32'hCAFEF00D, 0, 0, d, lat, e);
    @(negedge Clk);
    MFA = 1; READ_WRITE = 0; WORD_BYTE = 1; Address = 32'h20; DataIn = 32'h12345678;
    @(negedge Clk);
    Reset = 1; MFA = 0;
    @(negedge Clk);
    check("reset_in_wait_mfc", {31'd0, MFC}, 32'd0);
    check("reset_in_wait_dataout", DataOut, 32'd0);
    Reset = 0;
    txn(1, 1, 32'h20, 32'h0, 0, 0, d, lat, e);
    check("write_discarded_by_reset", d, 32'hCAFEF00D);

`ifdef MEM_ALIGN_CHECK_EN
    txn(0, 1, 32'h1FC, 32'hA5A51234, 0, 0, d, lat, e);
`else
    txn(0, 1, 32'h1FE, 32'hA5A51234, 0, 0, d, lat, e);
`endif
    txn(1, 1, 32'hFC, 32'h0, 0, 0, d, lat, e);
    check("wrap_align_fc", d, 32'hA5A51234);
    txn(0, 1, 32'h100, 32'h01020304, 0, 0, d, lat, e);
    txn(1, 1, 32'h0, 32'h0, 0, 0, d, lat, e);
    check("alias_100_to_0", d, 32'h01020304);

    txn(1, 1, 32'h10, 32'h0, 0, 1, d, lat, e);
    check("early_drop_read", d, 32'hDE55BEEF);

`ifdef MEM_ALIGN_CHECK_EN
    txn(0, 1, 32'h20, 32'h11223344, 0, 0, d, lat, e);
    txn(0, 1, 32'h21, 32'hFFFFFFFF, 0, 0, d, lat, e);
    check("misaligned_err", {31'd0, e}, 32'd1);
    txn(1, 1, 32'h20, 32'h0, 0, 0, d, lat, e);
    check("misaligned_no_write", d, 32'h11223344);
    txn(0, 0, 32'h21, 32'h99, 0, 0, d, lat, e);
    check("byte_no_err", {31'd0, e}, 32'd0);
    txn(1, 1, 32'h20, 32'h0, 0, 0, d, lat, e);
    check("byte_write_21", d, 32'h11229944);
`endif

    for (int i = 0; i < 60; i++)
      txn($urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom,
          $urandom_range(0, 3), ($urandom_range(0, 4) == 0), d, lat, e);

    repeat (3) @(negedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
